// File: rtl/modular_exponentiation_controller.sv
// ----------------------------------------------------------------------------
// modular_exponentiation_controller
//
// Computes base^exponent mod modulus with left-to-right square-and-multiply.
// The actual modular products are produced by an external modular multiplier
// that this block drives over valid/ready streams. One operation is in flight
// at a time; a new operand set is accepted only after the result is taken.
//
// Ports
//   clk, rst                     clock (rising edge), asynchronous active-low reset
//   input_base_*                 base operand stream (tdata/tvalid/tready)
//   input_exponent_*             exponent operand stream
//   input_modulus_*              modulus operand stream
//   output_*                     exponentiation result stream
//   mul_multiplier_*             multiplier operand stream to the multiplier
//   mul_multiplicand_*           multiplicand operand stream to the multiplier
//   mul_modulus_*                modulus operand stream to the multiplier
//   mul_result_*                 product stream back from the multiplier
//   busy                         high from operand set complete until result taken
//
// Every output comes straight from a register, so no ready input reaches any
// valid/data output combinationally.
// ----------------------------------------------------------------------------
module modular_exponentiation_controller #(
   parameter int SIZE = 64,
   parameter int IDXW = $clog2(SIZE)
) (
   input  logic            clk,
   input  logic            rst,

   input  logic [SIZE-1:0] input_base_tdata,
   input  logic            input_base_tvalid,
   output logic            input_base_tready,
   input  logic [SIZE-1:0] input_exponent_tdata,
   input  logic            input_exponent_tvalid,
   output logic            input_exponent_tready,
   input  logic [SIZE-1:0] input_modulus_tdata,
   input  logic            input_modulus_tvalid,
   output logic            input_modulus_tready,

   output logic [SIZE-1:0] output_tdata,
   output logic            output_tvalid,
   input  logic            output_tready,

   output logic [SIZE-1:0] mul_multiplier_tdata,
   output logic            mul_multiplier_tvalid,
   input  logic            mul_multiplier_tready,
   output logic [SIZE-1:0] mul_multiplicand_tdata,
   output logic            mul_multiplicand_tvalid,
   input  logic            mul_multiplicand_tready,
   output logic [SIZE-1:0] mul_modulus_tdata,
   output logic            mul_modulus_tvalid,
   input  logic            mul_modulus_tready,

   input  logic [SIZE-1:0] mul_result_tdata,
   input  logic            mul_result_tvalid,
   output logic            mul_result_tready,

   output logic            busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_SQ_ISSUE,
      S_SQ_WAIT,
      S_MUL_ISSUE,
      S_MUL_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [SIZE-1:0]   base_q, base_d;
   logic [SIZE-1:0]   exp_q, exp_d;
   logic [SIZE-1:0]   mod_q, mod_d;
   logic [SIZE-1:0]   acc_q, acc_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   // bit 0 base, bit 1 exponent, bit 2 modulus
   logic [2:0]        in_rdy_q, in_rdy_d;
   // bit 0 multiplier, bit 1 multiplicand, bit 2 modulus
   logic [2:0]        mul_vld_q, mul_vld_d;
   logic [SIZE-1:0]   mul_a_q, mul_a_d;
   logic [SIZE-1:0]   mul_b_q, mul_b_d;
   logic [SIZE-1:0]   mul_m_q, mul_m_d;
   logic              res_rdy_q, res_rdy_d;
   logic              out_vld_q, out_vld_d;
   logic [SIZE-1:0]   out_data_q, out_data_d;
   logic              busy_q, busy_d;

   logic [2:0]        mul_rdy;
   logic              res_fire;

   assign mul_rdy  = {mul_modulus_tready, mul_multiplicand_tready, mul_multiplier_tready};
   assign res_fire = mul_result_tvalid & res_rdy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         exp_q      <= '0;
         mod_q      <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         in_rdy_q   <= 3'b111;
         mul_vld_q  <= 3'b000;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         mul_m_q    <= '0;
         res_rdy_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         exp_q      <= exp_d;
         mod_q      <= mod_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         in_rdy_q   <= in_rdy_d;
         mul_vld_q  <= mul_vld_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         mul_m_q    <= mul_m_d;
         res_rdy_q  <= res_rdy_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      exp_d      = exp_q;
      mod_d      = mod_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      in_rdy_d   = in_rdy_q;
      mul_vld_d  = mul_vld_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      mul_m_d    = mul_m_q;
      res_rdy_d  = res_rdy_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      busy_d     = busy_q;

      case (state_q)
         S_IDLE: begin
            // Each operand is captured independently; its ready drops once held.
            if (input_base_tvalid && in_rdy_q[0]) begin
               base_d      = input_base_tdata;
               in_rdy_d[0] = 1'b0;
            end
            if (input_exponent_tvalid && in_rdy_q[1]) begin
               exp_d       = input_exponent_tdata;
               in_rdy_d[1] = 1'b0;
            end
            if (input_modulus_tvalid && in_rdy_q[2]) begin
               mod_d       = input_modulus_tdata;
               in_rdy_d[2] = 1'b0;
            end
            if (in_rdy_q == 3'b000) begin
               busy_d = 1'b1;
               acc_d  = SIZE'(1);
               idx_d  = IDXW'(SIZE - 1);
               // Everything reduces to 0 modulo 0 or 1; the multiplier is never used.
               if ((mod_q == '0) || (mod_q == SIZE'(1))) begin
                  acc_d      = '0;
                  out_data_d = '0;
                  out_vld_d  = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_SCAN;
               end
            end
         end

         S_SCAN: begin
            // Skip leading zero bits; an all-zero exponent leaves acc at 1.
            if (exp_q[idx_q]) begin
               mul_a_d   = acc_q;
               mul_b_d   = acc_q;
               mul_m_d   = mod_q;
               mul_vld_d = 3'b111;
               state_d   = S_SQ_ISSUE;
            end else if (idx_q == '0) begin
               out_data_d = acc_q;
               out_vld_d  = 1'b1;
               state_d    = S_DONE;
            end else begin
               idx_d = idx_q - IDXW'(1);
            end
         end

         S_SQ_ISSUE, S_MUL_ISSUE: begin
            // Channels complete independently; move on once none is pending.
            mul_vld_d = mul_vld_q & ~mul_rdy;
            if (mul_vld_d == 3'b000) begin
               res_rdy_d = 1'b1;
               state_d   = (state_q == S_SQ_ISSUE) ? S_SQ_WAIT : S_MUL_WAIT;
            end
         end

         S_SQ_WAIT: begin
            if (res_fire) begin
               acc_d     = mul_result_tdata;
               res_rdy_d = 1'b0;
               if (exp_q[idx_q]) begin
                  mul_a_d   = mul_result_tdata;
                  mul_b_d   = base_q;
                  mul_m_d   = mod_q;
                  mul_vld_d = 3'b111;
                  state_d   = S_MUL_ISSUE;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end

         S_MUL_WAIT: begin
            if (res_fire) begin
               acc_d     = mul_result_tdata;
               res_rdy_d = 1'b0;
               state_d   = S_NEXT;
            end
         end

         S_NEXT: begin
            if (idx_q == '0) begin
               out_data_d = acc_q;
               out_vld_d  = 1'b1;
               state_d    = S_DONE;
            end else begin
               idx_d     = idx_q - IDXW'(1);
               mul_a_d   = acc_q;
               mul_b_d   = acc_q;
               mul_m_d   = mod_q;
               mul_vld_d = 3'b111;
               state_d   = S_SQ_ISSUE;
            end
         end

         S_DONE: begin
            if (output_tready) begin
               out_vld_d = 1'b0;
               busy_d    = 1'b0;
               in_rdy_d  = 3'b111;
               state_d   = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign input_base_tready       = in_rdy_q[0];
   assign input_exponent_tready   = in_rdy_q[1];
   assign input_modulus_tready    = in_rdy_q[2];
   assign output_tdata            = out_data_q;
   assign output_tvalid           = out_vld_q;
   assign mul_multiplier_tdata    = mul_a_q;
   assign mul_multiplier_tvalid   = mul_vld_q[0];
   assign mul_multiplicand_tdata  = mul_b_q;
   assign mul_multiplicand_tvalid = mul_vld_q[1];
   assign mul_modulus_tdata       = mul_m_q;
   assign mul_modulus_tvalid      = mul_vld_q[2];
   assign mul_result_tready       = res_rdy_q;
   assign busy                    = busy_q;

endmodule

// File: tb/tb_modular_exponentiation_controller.sv
// ----------------------------------------------------------------------------
// Testbench for modular_exponentiation_controller. A behavioural modular
// multiplier answers the controller's operand streams; expected results come
// from a right-to-left binary exponentiation written with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_modular_exponentiation_controller;

   localparam int SIZE = 64;

   logic            clk;
   logic            rst;
   logic [SIZE-1:0] input_base_tdata, input_exponent_tdata, input_modulus_tdata;
   logic            input_base_tvalid, input_exponent_tvalid, input_modulus_tvalid;
   logic            input_base_tready, input_exponent_tready, input_modulus_tready;
   logic [SIZE-1:0] output_tdata;
   logic            output_tvalid, output_tready;
   logic [SIZE-1:0] mul_multiplier_tdata, mul_multiplicand_tdata, mul_modulus_tdata;
   logic            mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid;
   logic            mul_multiplier_tready, mul_multiplicand_tready, mul_modulus_tready;
   logic [SIZE-1:0] mul_result_tdata;
   logic            mul_result_tvalid, mul_result_tready;
   logic            busy;

   modular_exponentiation_controller #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst),
      .input_base_tdata(input_base_tdata), .input_base_tvalid(input_base_tvalid),
      .input_base_tready(input_base_tready),
      .input_exponent_tdata(input_exponent_tdata), .input_exponent_tvalid(input_exponent_tvalid),
      .input_exponent_tready(input_exponent_tready),
      .input_modulus_tdata(input_modulus_tdata), .input_modulus_tvalid(input_modulus_tvalid),
      .input_modulus_tready(input_modulus_tready),
      .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready),
      .mul_multiplier_tdata(mul_multiplier_tdata), .mul_multiplier_tvalid(mul_multiplier_tvalid),
      .mul_multiplier_tready(mul_multiplier_tready),
      .mul_multiplicand_tdata(mul_multiplicand_tdata), .mul_multiplicand_tvalid(mul_multiplicand_tvalid),
      .mul_multiplicand_tready(mul_multiplicand_tready),
      .mul_modulus_tdata(mul_modulus_tdata), .mul_modulus_tvalid(mul_modulus_tvalid),
      .mul_modulus_tready(mul_modulus_tready),
      .mul_result_tdata(mul_result_tdata), .mul_result_tvalid(mul_result_tvalid),
      .mul_result_tready(mul_result_tready),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] e,
                                              input logic [63:0] m);
      logic [127:0] r, bb, mm;
      logic [63:0]  ee;
      if (m < 64'd2) return 64'd0;
      mm = {64'd0, m};
      r  = 128'd1;
      bb = {64'd0, b} % mm;
      ee = e;
      while (ee != 64'd0) begin
         if (ee[0]) r = (r * bb) % mm;
         bb = (bb * bb) % mm;
         ee = ee >> 1;
      end
      return r[63:0];
   endfunction

   // squares: every bit from the highest set bit down to bit 0; multiplies: one per set bit
   function automatic int ref_ops(input logic [63:0] e, input logic [63:0] m);
      int msb;
      if (m < 64'd2 || e == 64'd0) return 0;
      msb = 0;
      for (int k = 0; k < 64; k++) if (e[k]) msb = k;
      return (msb + 1) + $countones(e);
   endfunction

   // ---------------- behavioural multiplier ----------------
   bit          stall_en;
   bit          mdl_hold;
   bit          mdl_clear;
   int          mul_ops;
   int          stab_viol;

   initial begin
      logic [SIZE-1:0] cap [3];
      logic [SIZE-1:0] pd  [3];
      logic [SIZE-1:0] d   [3];
      bit              have [3];
      bit              pv [3], pr [3], v [3], r [3];
      bit              res_v, res_fire, was_all, prst;
      logic [SIZE-1:0] res_d;
      logic [127:0]    prod;
      int              dly;
      mul_multiplier_tready   = 1'b0;
      mul_multiplicand_tready = 1'b0;
      mul_modulus_tready      = 1'b0;
      mul_result_tvalid       = 1'b0;
      mul_result_tdata        = '0;
      mul_ops   = 0;
      stab_viol = 0;
      res_v = 0; res_fire = 0; dly = 0; prst = 0; res_d = '0;
      for (int i = 0; i < 3; i++) begin
         have[i] = 0; pv[i] = 0; pr[i] = 0; pd[i] = '0; cap[i] = '0;
      end
      forever begin
         @(negedge clk);
         v[0] = mul_multiplier_tvalid;   d[0] = mul_multiplier_tdata;
         v[1] = mul_multiplicand_tvalid; d[1] = mul_multiplicand_tdata;
         v[2] = mul_modulus_tvalid;      d[2] = mul_modulus_tdata;
         // an offered operand that was not taken must still be offered, unchanged
         for (int i = 0; i < 3; i++)
            if (rst && prst && pv[i] && !pr[i] && (!v[i] || d[i] != pd[i])) stab_viol++;
         if (mdl_clear || res_fire) begin
            res_v = 0; res_fire = 0; dly = 0;
            for (int i = 0; i < 3; i++) have[i] = 0;
         end
         was_all = have[0] && have[1] && have[2];
         for (int i = 0; i < 3; i++) begin
            r[i] = have[i] ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
            if (v[i] && r[i]) begin
               cap[i]  = d[i];
               have[i] = 1;
            end
         end
         if (!was_all && have[0] && have[1] && have[2]) begin
            mul_ops++;
            dly = stall_en ? int'($urandom_range(0, 4)) : 0;
         end
         if (have[0] && have[1] && have[2] && !res_v && !mdl_hold) begin
            if (dly == 0) begin
               prod  = (cap[2] == '0) ? 128'd0 :
                       ({64'd0, cap[0]} * {64'd0, cap[1]}) % {64'd0, cap[2]};
               res_d = prod[63:0];
               res_v = 1;
            end else begin
               dly--;
            end
         end
         if (res_v && mul_result_tready) res_fire = 1;
         mul_multiplier_tready   = r[0];
         mul_multiplicand_tready = r[1];
         mul_modulus_tready      = r[2];
         mul_result_tvalid       = res_v;
         mul_result_tdata        = res_d;
         for (int i = 0; i < 3; i++) begin
            pv[i] = v[i]; pr[i] = r[i]; pd[i] = d[i];
         end
         prst = rst;
      end
   end

   // ---------------- checking helpers ----------------
   int n_checks;
   int n_fail;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 64'(output_tvalid), 64'd0);
      chk({tag, "_out_data"}, output_tdata, 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_in_readies"},
          64'({input_base_tready, input_exponent_tready, input_modulus_tready}), 64'd7);
      chk({tag, "_mul_valids"},
          64'({mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid}), 64'd0);
      chk({tag, "_mul_data"},
          mul_multiplier_tdata | mul_multiplicand_tdata | mul_modulus_tdata, 64'd0);
      chk({tag, "_res_ready"}, 64'(mul_result_tready), 64'd0);
   endtask

   task automatic send_all(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
      @(negedge clk);
      input_base_tdata = b; input_exponent_tdata = e; input_modulus_tdata = m;
      input_base_tvalid = 1; input_exponent_tvalid = 1; input_modulus_tvalid = 1;
      @(negedge clk);
      input_base_tvalid = 0; input_exponent_tvalid = 0; input_modulus_tvalid = 0;
   endtask

   task automatic wait_out();
      int cyc;
      cyc = 0;
      while (!output_tvalid && cyc < 6000) begin
         @(negedge clk);
         cyc++;
      end
      chk("out_valid_seen", 64'(output_tvalid), 64'd1);
   endtask

   task automatic run_op(input string name, input logic [63:0] b, input logic [63:0] e,
                         input logic [63:0] m, input logic [63:0] res, input int ops);
      int ops0;
      chk({name, "_idle_readies"},
          64'({input_base_tready, input_exponent_tready, input_modulus_tready}), 64'd7);
      ops0 = mul_ops;
      send_all(b, e, m);
      wait_out();
      chk({name, "_result"}, output_tdata, res);
      chk({name, "_mul_ops"}, 64'(mul_ops - ops0), 64'(ops));
      @(negedge clk);
      chk({name, "_out_valid_drop"}, 64'(output_tvalid), 64'd0);
      chk({name, "_busy_clear"}, 64'(busy), 64'd0);
   endtask

   typedef struct {
      logic [63:0] b;
      logic [63:0] e;
      logic [63:0] m;
      logic [63:0] res;
      int          ops;
      bit          stall;
   } vec_t;

   vec_t vt [10];

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] hres;
      int          cyc;
      n_checks = 0; n_fail = 0;
      stall_en = 0; mdl_hold = 0; mdl_clear = 0;
      rst = 0;
      input_base_tdata = '0; input_exponent_tdata = '0; input_modulus_tdata = '0;
      input_base_tvalid = 0; input_exponent_tvalid = 0; input_modulus_tvalid = 0;
      output_tready = 1;

      vt[0] = '{b: 64'd3, e: 64'd5, m: 64'd7, res: 64'd5, ops: 5, stall: 0};
      vt[1] = '{b: 64'd11, e: 64'd0, m: 64'd69814, res: 64'd1, ops: 0, stall: 0};
      vt[2] = '{b: 64'd123456789, e: 64'd77, m: 64'd1, res: 64'd0, ops: 0, stall: 0};
      vt[3] = '{b: 64'd987654321, e: 64'd12345, m: 64'd0, res: 64'd0, ops: 0, stall: 0};
      vt[4] = '{b: 64'd143563561627, e: 64'd65537, m: 64'd69814,
                res: ref_modexp(64'd143563561627, 64'd65537, 64'd69814), ops: 19, stall: 1};
      vt[5] = '{b: 64'd2, e: 64'd10, m: 64'd1000, res: 64'd24, ops: 6, stall: 1};
      for (int i = 6; i < 10; i++) begin
         vt[i].b = {$urandom, $urandom};
         vt[i].e = (i == 6) ? 64'({$urandom} & 32'hFFFF) : {$urandom, $urandom};
         vt[i].m = {$urandom, $urandom} | 64'd2;
         vt[i].res   = ref_modexp(vt[i].b, vt[i].e, vt[i].m);
         vt[i].ops   = ref_ops(vt[i].e, vt[i].m);
         vt[i].stall = 1;
      end

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1;
      @(negedge clk);

      // table-driven operations, some with independent random stalls
      for (int i = 0; i < 10; i++) begin
         stall_en = vt[i].stall;
         run_op($sformatf("vec%0d", i), vt[i].b, vt[i].e, vt[i].m, vt[i].res, vt[i].ops);
      end
      chk("operand_stable", 64'(stab_viol), 64'd0);
      stall_en = 0;

      // operands on separate cycles, modulus first; readies drop one at a time
      @(negedge clk);
      input_modulus_tdata = 64'd1000; input_modulus_tvalid = 1;
      @(negedge clk);
      input_modulus_tvalid = 0;
      chk("ord_mod_ready", 64'({input_base_tready, input_exponent_tready, input_modulus_tready}), 64'd6);
      chk("ord_busy0", 64'(busy), 64'd0);
      @(negedge clk);
      input_exponent_tdata = 64'd10; input_exponent_tvalid = 1;
      @(negedge clk);
      input_exponent_tvalid = 0;
      chk("ord_exp_ready", 64'({input_base_tready, input_exponent_tready, input_modulus_tready}), 64'd4);
      @(negedge clk);
      input_base_tdata = 64'd2; input_base_tvalid = 1;
      @(negedge clk);
      input_base_tvalid = 0;
      chk("ord_base_ready", 64'({input_base_tready, input_exponent_tready, input_modulus_tready}), 64'd0);
      @(negedge clk);
      chk("ord_busy1", 64'(busy), 64'd1);
      wait_out();
      chk("ord_result", output_tdata, 64'd24);
      @(negedge clk);
      chk("ord_out_drop", 64'(output_tvalid), 64'd0);

      // result held while the consumer stalls
      hres = ref_modexp(64'd7, 64'd13, 64'd101);
      output_tready = 0;
      send_all(64'd7, 64'd13, 64'd101);
      wait_out();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("hold_valid", 64'(output_tvalid), 64'd1);
         chk("hold_data", output_tdata, hres);
         chk("hold_readies", 64'({input_base_tready, input_exponent_tready, input_modulus_tready}), 64'd0);
         chk("hold_busy", 64'(busy), 64'd1);
      end
      output_tready = 1;
      @(negedge clk);
      chk("hold_release_valid", 64'(output_tvalid), 64'd0);
      chk("hold_release_busy", 64'(busy), 64'd0);
      chk("hold_release_readies", 64'({input_base_tready, input_exponent_tready, input_modulus_tready}), 64'd7);

      // reset while waiting on the first square; the late product must be ignored
      mdl_hold = 1;
      send_all(64'd3, 64'd5, 64'd7);
      cyc = 0;
      while (!mul_result_tready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("sqwait_reached", 64'(mul_result_tready), 64'd1);
      rst = 0;
      #1;
      chk_reset_vals("midreset");
      @(negedge clk);
      chk_reset_vals("midreset_hold");
      rst = 1;
      mdl_hold = 0;
      repeat (3) begin
         @(negedge clk);
         chk("stale_res_ready", 64'(mul_result_tready), 64'd0);
         chk("stale_busy", 64'(busy), 64'd0);
      end
      chk("stale_valid_present", 64'(mul_result_tvalid), 64'd1);
      mdl_clear = 1;
      repeat (2) @(negedge clk);
      mdl_clear = 0;
      run_op("after_reset", 64'd3, 64'd5, 64'd7, 64'd5, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
